// File: rtl/l1i_miss_handler_pkg.sv
// Shared types for the icache miss/fill path.
// Line geometry, index types and the miss entry bundle.
package l1i_miss_handler_pkg;

  localparam int THREADS_PER_CORE = 4;
  localparam int L1I_WAYS = 4;
  localparam int L1I_SETS = 64;
  localparam int CACHE_LINE_BYTES = 64;
  localparam int PADDR_W = 32;
  localparam int OFFSET_W = $clog2(CACHE_LINE_BYTES);
  localparam int SET_W = $clog2(L1I_SETS);
  localparam int LINE_W = PADDR_W - OFFSET_W;
  localparam int TAG_W = LINE_W - SET_W;
  localparam int LINE_BITS = CACHE_LINE_BYTES * 8;

  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;
  typedef logic [THREADS_PER_CORE-1:0] local_thread_bitmap_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] l1i_miss_entry_idx_t;
  typedef logic [LINE_W-1:0] cache_line_index_t;
  typedef logic [LINE_BITS-1:0] cache_line_data_t;
  typedef logic [SET_W-1:0] l1i_set_idx_t;
  typedef logic [TAG_W-1:0] l1i_tag_t;
  typedef logic [$clog2(L1I_WAYS)-1:0] l1i_way_idx_t;
  typedef logic [L1I_WAYS-1:0] l1i_way_bitmap_t;

  typedef struct packed {
    logic                 valid;
    logic                 sent;
    cache_line_index_t    line;
    local_thread_bitmap_t waiters;
  } l1i_miss_entry_t;

  function automatic l1i_set_idx_t line_set(
    input cache_line_index_t l
  );
    return l[SET_W-1:0];
  endfunction

  function automatic l1i_tag_t line_tag(
    input cache_line_index_t l
  );
    return l[LINE_W-1:SET_W];
  endfunction

  function automatic l1i_way_bitmap_t way_oh(
    input l1i_way_idx_t w
  );
    return l1i_way_bitmap_t'(1) << w;
  endfunction

  function automatic local_thread_bitmap_t thread_oh(
    input local_thread_idx_t t
  );
    return local_thread_bitmap_t'(1) << t;
  endfunction

endpackage

// File: rtl/l1i_miss_handler_if.sv
// L2 request/response channel of the icache fill path.
// master = miss handler, slave = L2 arbiter/response side.
interface l1i_miss_handler_if;
  import l1i_miss_handler_pkg::*;

  logic                l2i_request_valid;
  cache_line_index_t   l2i_request_addr;
  l1i_miss_entry_idx_t l2i_request_entry;
  logic                l2_request_ack;
  logic                l2_response_valid;
  l1i_miss_entry_idx_t l2_response_entry;
  cache_line_data_t    l2_response_data;

  modport master (
    output l2i_request_valid,
    output l2i_request_addr,
    output l2i_request_entry,
    input  l2_request_ack,
    input  l2_response_valid,
    input  l2_response_entry,
    input  l2_response_data
  );

  modport slave (
    input  l2i_request_valid,
    input  l2i_request_addr,
    input  l2i_request_entry,
    output l2_request_ack,
    output l2_response_valid,
    output l2_response_entry,
    output l2_response_data
  );

endinterface

// File: rtl/l1i_miss_entry.sv
// One miss entry: state flops, line CAM compare,
// allocate / merge waiters / mark sent / free.
module l1i_miss_entry
  import l1i_miss_handler_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 miss,
  input  cache_line_index_t    miss_line,
  input  local_thread_bitmap_t miss_oh,
  input  logic                 alloc,
  input  logic                 send,
  input  logic                 free,
  output logic                 cam_hit,
  output l1i_miss_entry_t      entry
);

  l1i_miss_entry_t q;

  assign cam_hit = q.valid && (q.line == miss_line);
  assign entry = q;

  // free wins: a same-line miss during the final fill
  // cycle is woken directly by the top level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (free) begin
      q <= '0;
    end else if (alloc) begin
      q.valid   <= 1'b1;
      q.sent    <= 1'b0;
      q.line    <= miss_line;
      q.waiters <= miss_oh;
    end else begin
      if (send)
        q.sent <= 1'b1;
      if (miss && cam_hit)
        q.waiters <= q.waiters | miss_oh;
    end
  end

endmodule

// File: rtl/l1i_miss_handler.sv
// Icache miss handler: merges per-line misses, issues one L2
// request per line, fills tag/data via LRU victim, wakes threads.
module l1i_miss_handler
  import l1i_miss_handler_pkg::*;
#(
  parameter int NUM_ENTRIES = THREADS_PER_CORE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ifd_cache_miss,
  input  logic [PADDR_W-1:0]   ifd_cache_miss_paddr,
  input  local_thread_idx_t    ifd_cache_miss_thread_idx,
  l1i_miss_handler_if.master   l2,
  output logic                 l2i_icache_lru_fill_en,
  output l1i_set_idx_t         l2i_icache_lru_fill_set,
  input  l1i_way_idx_t         ift_fill_lru,
  output l1i_way_bitmap_t      l2i_itag_update_en,
  output l1i_set_idx_t         l2i_itag_update_set,
  output l1i_tag_t             l2i_itag_update_tag,
  output logic                 l2i_itag_update_valid,
  output logic                 l2i_idata_update_en,
  output l1i_way_idx_t         l2i_idata_update_way,
  output l1i_set_idx_t         l2i_idata_update_set,
  output cache_line_data_t     l2i_idata_update_data,
  output local_thread_bitmap_t l2i_icache_wake_bitmap
);

  cache_line_index_t    miss_line;
  local_thread_bitmap_t miss_oh;
  logic                 unused_offset;

  logic [NUM_ENTRIES-1:0] cam_hit;
  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] sent;
  logic [NUM_ENTRIES-1:0] req;
  logic [NUM_ENTRIES-1:0] alloc;
  logic [NUM_ENTRIES-1:0] send;
  logic [NUM_ENTRIES-1:0] free;
  l1i_miss_entry_t        entries [NUM_ENTRIES];

  logic                alloc_found;
  logic                rr_found;
  l1i_miss_entry_idx_t rr_idx;
  l1i_miss_entry_idx_t cand;
  l1i_miss_entry_idx_t last_q;
  logic                hold_q;
  l1i_miss_entry_idx_t hold_idx_q;
  logic                req_valid;
  logic                req_fire;
  l1i_miss_entry_idx_t grant_idx;

  logic                s1_valid;
  l1i_miss_entry_idx_t s1_entry;
  cache_line_data_t    s1_data;
  logic                s2_valid;
  l1i_miss_entry_idx_t s2_entry;
  cache_line_data_t    s2_data;
  cache_line_index_t   s2_line;
  logic                s2_same_miss;

  assign miss_line = ifd_cache_miss_paddr[PADDR_W-1:OFFSET_W];
  assign miss_oh = thread_oh(ifd_cache_miss_thread_idx);
  assign unused_offset = ^ifd_cache_miss_paddr[OFFSET_W-1:0];

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
    l1i_miss_entry u_entry (
      .clk       (clk),
      .reset_n   (reset_n),
      .miss      (ifd_cache_miss),
      .miss_line (miss_line),
      .miss_oh   (miss_oh),
      .alloc     (alloc[i]),
      .send      (send[i]),
      .free      (free[i]),
      .cam_hit   (cam_hit[i]),
      .entry     (entries[i])
    );
    assign valid[i] = entries[i].valid;
    assign sent[i]  = entries[i].sent;
  end

  // lowest free slot; a slot being freed is still valid here
  always_comb begin
    alloc = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!valid[i] && !alloc_found) begin
        alloc[i] = ifd_cache_miss && !(|cam_hit);
        alloc_found = 1'b1;
      end
    end
  end

  assign req = valid & ~sent;

  always_comb begin
    rr_idx = '0;
    rr_found = 1'b0;
    cand = '0;
    for (int k = 1; k <= NUM_ENTRIES; k++) begin
      cand = l1i_miss_entry_idx_t'((int'(last_q) + k) % NUM_ENTRIES);
      if (req[cand] && !rr_found) begin
        rr_idx = cand;
        rr_found = 1'b1;
      end
    end
  end

  // once presented, a request is locked until the arbiter acks
  assign req_valid = hold_q || (|req);
  assign grant_idx = hold_q ? hold_idx_q : rr_idx;
  assign req_fire  = req_valid && l2.l2_request_ack;

  assign l2.l2i_request_valid = req_valid;
  assign l2.l2i_request_entry = req_valid ? grant_idx : '0;
  assign l2.l2i_request_addr  =
    req_valid ? entries[grant_idx].line : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q     <= 1'b0;
      hold_idx_q <= '0;
      last_q     <= l1i_miss_entry_idx_t'(NUM_ENTRIES - 1);
    end else begin
      hold_q <= req_valid && !l2.l2_request_ack;
      if (req_valid && !l2.l2_request_ack)
        hold_idx_q <= grant_idx;
      if (req_fire)
        last_q <= grant_idx;
    end
  end

  always_comb begin
    send = '0;
    free = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      send[i] = req_fire &&
                (grant_idx == l1i_miss_entry_idx_t'(i));
      free[i] = s2_valid &&
                (s2_entry == l1i_miss_entry_idx_t'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_entry <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= l2.l2_response_valid;
      s1_entry <= l2.l2_response_entry;
      s1_data  <= l2.l2_response_data;
      s2_valid <= s1_valid;
      s2_entry <= s1_entry;
      s2_data  <= s1_data;
    end
  end

  assign l2i_icache_lru_fill_en  = s1_valid;
  assign l2i_icache_lru_fill_set =
    s1_valid ? line_set(entries[s1_entry].line) : '0;

  assign s2_line = entries[s2_entry].line;
  assign s2_same_miss = s2_valid && ifd_cache_miss && cam_hit[s2_entry];

  assign l2i_itag_update_en =
    s2_valid ? way_oh(ift_fill_lru) : '0;
  assign l2i_itag_update_set   = s2_valid ? line_set(s2_line) : '0;
  assign l2i_itag_update_tag   = s2_valid ? line_tag(s2_line) : '0;
  assign l2i_itag_update_valid = s2_valid;
  assign l2i_idata_update_en   = s2_valid;
  assign l2i_idata_update_way  = s2_valid ? ift_fill_lru : '0;
  assign l2i_idata_update_set  = s2_valid ? line_set(s2_line) : '0;
  assign l2i_idata_update_data = s2_valid ? s2_data : '0;

  assign l2i_icache_wake_bitmap =
    s2_valid ? (entries[s2_entry].waiters |
                (s2_same_miss ? miss_oh : '0)) : '0;

  a_no_free: assert property (
    @(posedge clk) disable iff (!reset_n)
    ifd_cache_miss |-> ((|cam_hit) || !(&valid)));

  a_resp_entry: assert property (
    @(posedge clk) disable iff (!reset_n)
    l2.l2_response_valid |->
      (valid[l2.l2_response_entry] && sent[l2.l2_response_entry]));

endmodule

// File: tb/tb_l1i_miss_handler.sv
// Scoreboard bench for l1i_miss_handler: directed misses/acks/responses
// push expectations; a negedge monitor pops and compares.
module tb_l1i_miss_handler
  import l1i_miss_handler_pkg::*;
();

  typedef struct {
    logic [25:0] line;
    logic [1:0]  entry;
  } req_t;

  typedef struct {
    int          cyc;
    logic [5:0]  set;
  } fe_t;

  typedef struct {
    int           cyc;
    logic [5:0]   set;
    logic [19:0]  tag;
    logic [1:0]   way;
    logic [511:0] data;
    logic [3:0]   wake;
  } wr_t;

  logic clk = 1'b0;
  logic reset_n;
  logic miss;
  logic [31:0] paddr;
  local_thread_idx_t tid;
  l1i_way_idx_t lru;
  logic fill_en;
  l1i_set_idx_t fill_set;
  l1i_way_bitmap_t tag_en;
  l1i_set_idx_t tag_set;
  l1i_tag_t tag_val;
  logic tag_vld;
  logic data_en;
  l1i_way_idx_t data_way;
  l1i_set_idx_t data_set;
  cache_line_data_t data_val;
  local_thread_bitmap_t wake;

  l1i_miss_handler_if l2_bus ();

  l1i_miss_handler dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .ifd_cache_miss            (miss),
    .ifd_cache_miss_paddr      (paddr),
    .ifd_cache_miss_thread_idx (tid),
    .l2                        (l2_bus),
    .l2i_icache_lru_fill_en    (fill_en),
    .l2i_icache_lru_fill_set   (fill_set),
    .ift_fill_lru              (lru),
    .l2i_itag_update_en        (tag_en),
    .l2i_itag_update_set       (tag_set),
    .l2i_itag_update_tag       (tag_val),
    .l2i_itag_update_valid     (tag_vld),
    .l2i_idata_update_en       (data_en),
    .l2i_idata_update_way      (data_way),
    .l2i_idata_update_set      (data_set),
    .l2i_idata_update_data     (data_val),
    .l2i_icache_wake_bitmap    (wake)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  req_t rq[$];
  fe_t  fq[$];
  wr_t  wq[$];

  task automatic chk(input string name,
                     input logic [511:0] act,
                     input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  logic pv = 1'b0;
  logic pa = 1'b0;
  logic [25:0] paddr_q;
  logic [1:0] pent_q;

  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_outs",
          |{l2_bus.l2i_request_valid, l2_bus.l2i_request_addr,
            l2_bus.l2i_request_entry, fill_en, fill_set, tag_en,
            tag_set, tag_val, tag_vld, data_en, data_way, data_set,
            data_val, wake}, 1'b0);
      pv = 1'b0;
    end else begin
      if (pv && !pa) begin
        chk("req_hold_valid", l2_bus.l2i_request_valid, 1'b1);
        chk("req_hold_addr", l2_bus.l2i_request_addr, paddr_q);
        chk("req_hold_entry", l2_bus.l2i_request_entry, pent_q);
      end
      if (l2_bus.l2i_request_valid) begin
        chk("req_pending", rq.size() != 0, 1'b1);
        if (rq.size() != 0) begin
          chk("req_addr", l2_bus.l2i_request_addr, rq[0].line);
          chk("req_entry", l2_bus.l2i_request_entry, rq[0].entry);
          if (l2_bus.l2_request_ack)
            void'(rq.pop_front());
        end
      end
      pv = l2_bus.l2i_request_valid;
      pa = l2_bus.l2_request_ack;
      paddr_q = l2_bus.l2i_request_addr;
      pent_q = l2_bus.l2i_request_entry;

      if (fill_en) begin
        chk("fill_en_pending", fq.size() != 0, 1'b1);
        if (fq.size() != 0) begin
          fe_t f;
          f = fq.pop_front();
          chk("fill_en_cycle", cyc, f.cyc);
          chk("fill_set", fill_set, f.set);
        end
      end

      if ((|tag_en) || data_en || (|wake)) begin
        chk("write_pending", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          wr_t w;
          l1i_way_bitmap_t oh;
          w = wq.pop_front();
          oh = '0;
          oh[w.way] = 1'b1;
          chk("write_cycle", cyc, w.cyc);
          chk("tag_en", tag_en, oh);
          chk("tag_set", tag_set, w.set);
          chk("tag_val", tag_val, w.tag);
          chk("tag_valid", tag_vld, 1'b1);
          chk("data_en", data_en, 1'b1);
          chk("data_way", data_way, w.way);
          chk("data_set", data_set, w.set);
          chk("data_val", data_val, w.data);
          chk("wake", wake, w.wake);
        end
      end
    end
  end

  // stimulus
  task automatic tick();
    @(posedge clk);
    #1;
    miss = 1'b0;
    l2_bus.l2_request_ack = 1'b0;
    l2_bus.l2_response_valid = 1'b0;
  endtask

  task automatic do_miss(input logic [1:0] t,
                         input logic [31:0] a,
                         input logic new_req,
                         input logic [25:0] line,
                         input logic [1:0] ent,
                         input logic with_ack);
    miss = 1'b1;
    tid = t;
    paddr = a;
    l2_bus.l2_request_ack = with_ack;
    if (new_req) rq.push_back('{line, ent});
    tick();
  endtask

  task automatic ack1();
    l2_bus.l2_request_ack = 1'b1;
    tick();
  endtask

  task automatic respond(input logic [1:0] ent,
                         input logic [511:0] d,
                         input logic expect_fill,
                         input logic [5:0] set,
                         input logic [19:0] tag,
                         input logic [1:0] way,
                         input logic [3:0] wk);
    l2_bus.l2_response_valid = 1'b1;
    l2_bus.l2_response_entry = ent;
    l2_bus.l2_response_data = d;
    if (expect_fill) begin
      fq.push_back('{cyc + 1, set});
      wq.push_back('{cyc + 2, set, tag, way, d, wk});
    end
  endtask

  logic [31:0]  t3_addr [4] = '{32'h0000_3080, 32'h1234_5FC0,
                                32'hFFFF_F000, 32'h8000_0FFF};
  logic [25:0]  t3_line [4] = '{26'h00000C2, 26'h048D17F,
                                26'h3FFFFC0, 26'h200003F};
  logic [5:0]   t3_set  [4] = '{6'h02, 6'h3F, 6'h00, 6'h3F};
  logic [19:0]  t3_tag  [4] = '{20'h00003, 20'h12345,
                                20'hFFFFF, 20'h80000};
  logic [1:0]   t4_ent  [4] = '{2'd2, 2'd0, 2'd1, 2'd3};
  logic [1:0]   t4_way  [4] = '{2'd1, 2'd3, 2'd0, 2'd2};

  initial begin
    reset_n = 1'b0;
    miss = 1'b0;
    paddr = '0;
    tid = '0;
    lru = '0;
    l2_bus.l2_request_ack = 1'b0;
    l2_bus.l2_response_valid = 1'b0;
    l2_bus.l2_response_entry = '0;
    l2_bus.l2_response_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();

    // 1: single miss, ack at N+3
    do_miss(2'd1, 32'h0000_1040, 1'b1, 26'h41, 2'd0, 1'b0);
    tick();
    tick();
    ack1();
    lru = 2'd2;
    respond(2'd0, {16{32'h1111_0001}}, 1'b1,
            6'h01, 20'h00001, 2'd2, 4'b0010);
    tick();
    repeat (4) tick();

    // 2: merge three threads, ack at N+1
    do_miss(2'd0, 32'h0000_2000, 1'b1, 26'h80, 2'd0, 1'b0);
    do_miss(2'd2, 32'h0000_2004, 1'b0, 26'h0, 2'd0, 1'b1);
    do_miss(2'd3, 32'h0000_203C, 1'b0, 26'h0, 2'd0, 1'b0);
    lru = 2'd0;
    respond(2'd0, {16{32'h2222_0002}}, 1'b1,
            6'h00, 20'h00002, 2'd0, 4'b1101);
    tick();
    repeat (4) tick();

    // 3: four lines, ack held low, round-robin issue
    for (int i = 0; i < 4; i++)
      do_miss(2'(i), t3_addr[i], 1'b1, t3_line[i], 2'(i), 1'b0);
    repeat (5) tick();
    repeat (4) ack1();

    // 4: back-to-back responses 2,0,1,3
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        int e;
        e = int'(t4_ent[k]);
        respond(t4_ent[k], {16{32'hA5A5_0000 + 32'(k)}}, 1'b1,
                t3_set[e], t3_tag[e], t4_way[k],
                4'(1 << e));
      end
      if (k >= 2) lru = t4_way[k-2];
      tick();
    end
    repeat (3) tick();

    // 5: stage-1 merge (t1) and stage-2 same-line miss (t3)
    do_miss(2'd0, 32'h0000_4A7C, 1'b1, 26'h129, 2'd0, 1'b0);
    ack1();
    lru = 2'd1;
    respond(2'd0, {16{32'h5555_0005}}, 1'b1,
            6'h29, 20'h00004, 2'd1, 4'b1011);
    tick();
    do_miss(2'd1, 32'h0000_4A40, 1'b0, 26'h0, 2'd0, 1'b0);
    do_miss(2'd3, 32'h0000_4A44, 1'b0, 26'h0, 2'd0, 1'b0);
    repeat (3) tick();

    // 6: reset during stage 1 drops the fill
    do_miss(2'd2, 32'h0000_5000, 1'b1, 26'h140, 2'd0, 1'b0);
    ack1();
    respond(2'd0, {16{32'h6666_0006}}, 1'b0,
            6'h00, 20'h00005, 2'd0, 4'b0100);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    do_miss(2'd1, 32'h0000_6040, 1'b1, 26'h181, 2'd0, 1'b0);
    ack1();
    lru = 2'd0;
    respond(2'd0, {16{32'h7777_0007}}, 1'b1,
            6'h01, 20'h00006, 2'd0, 4'b0010);
    tick();

    for (int i = 0; i < 30; i++) begin
      if (rq.size() == 0 && fq.size() == 0 && wq.size() == 0)
        break;
      tick();
    end
    repeat (2) tick();
    chk("req_queue_drained", rq.size(), 0);
    chk("fill_queue_drained", fq.size(), 0);
    chk("write_queue_drained", wq.size(), 0);
    chk("req_idle_at_end", l2_bus.l2i_request_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
